// File: rtl/gem_cluster_lut_scheduler_pkg.sv
// Shared definitions for the GEM cluster LUT scheduler: FSM states and field widths.
package gem_cluster_lut_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam int SLOT_W = 3;
    localparam int ROLL_W = 3;
    localparam int PAD_W  = 8;
    localparam int SIZE_W = 3;
    localparam int WIRE_W = 6;
    localparam int HS_W   = 8;

endpackage

// File: rtl/gem_sched_tag_pipe.sv
// Fixed-depth shift register of {valid, slot} tags that tracks in-flight translator lookups.
module gem_sched_tag_pipe
    import gem_cluster_lut_scheduler_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push_vld,
    input  logic [SLOT_W-1:0] i_push_slot,
    output logic              o_vld,
    output logic [SLOT_W-1:0] o_slot
);

    logic [DEPTH-1:0]  r_vld;
    logic [SLOT_W-1:0] r_slot [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_slot[i] <= '0;
        end else begin
            r_vld[0]  <= i_flush ? 1'b0 : i_push_vld;
            r_slot[0] <= i_push_slot;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= i_flush ? 1'b0 : r_vld[i-1];
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_slot = r_slot[DEPTH-1];

endmodule

// File: rtl/gem_cluster_lut_scheduler.sv
// Issues up to eight GEM clusters through one shared translator and banks the returned windows per slot.
// Define GEM_SCHED_SKIP_INVALID_EN to skip invalid slots instead of walking all eight in order.
module gem_cluster_lut_scheduler
    import gem_cluster_lut_scheduler_pkg::*;
#(
    parameter int NCLUSTERS   = 8,
    parameter int TRN_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [NCLUSTERS-1:0]          cl_vpf,
    input  logic [NCLUSTERS*ROLL_W-1:0]   cl_roll,
    input  logic [NCLUSTERS*PAD_W-1:0]    cl_pad,
    input  logic [NCLUSTERS*SIZE_W-1:0]   cl_size,
    output logic                          trn_vpf,
    output logic [ROLL_W-1:0]             trn_roll,
    output logic [PAD_W-1:0]              trn_pad,
    output logic [SIZE_W-1:0]             trn_size,
    input  logic [WIRE_W-1:0]             trn_wire_lo,
    input  logic [WIRE_W-1:0]             trn_wire_hi,
    input  logic [HS_W-1:0]               trn_hs_lo,
    input  logic [HS_W-1:0]               trn_hs_hi,
    input  logic                          trn_me1a,
    output logic [NCLUSTERS-1:0]          res_vpf,
    output logic [NCLUSTERS*WIRE_W-1:0]   res_wire_lo,
    output logic [NCLUSTERS*WIRE_W-1:0]   res_wire_hi,
    output logic [NCLUSTERS*HS_W-1:0]     res_hs_lo,
    output logic [NCLUSTERS*HS_W-1:0]     res_hs_hi,
    output logic [NCLUSTERS-1:0]          res_me1a,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    sched_state_t r_state, w_state_nxt;

    logic [NCLUSTERS-1:0]        r_vpf, r_pend, w_pend_left;
    logic [NCLUSTERS*ROLL_W-1:0] r_roll;
    logic [NCLUSTERS*PAD_W-1:0]  r_pad;
    logic [NCLUSTERS*SIZE_W-1:0] r_size;
    logic [1:0]                  r_drain;
    logic                        r_overrun;

    logic [NCLUSTERS-1:0]        r_res_vpf, r_res_me1a;
    logic [NCLUSTERS*WIRE_W-1:0] r_res_wlo, r_res_whi;
    logic [NCLUSTERS*HS_W-1:0]   r_res_hlo, r_res_hhi;

    logic [SLOT_W-1:0] w_sel, w_tag_slot;
    logic              w_any, w_issue_slot, w_issue_vld, w_tag_vld;

`ifdef GEM_SCHED_SKIP_INVALID_EN
    localparam logic SKIP_INVALID = 1'b1;
`else
    localparam logic SKIP_INVALID = 1'b0;
`endif

    // Lowest pending slot wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int unsigned i = NCLUSTERS; i > 0; i--) begin
            if (r_pend[i-1]) begin
                w_sel = SLOT_W'(i - 1);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_issue_slot = (r_state == S_ISSUE) && w_any;
        w_issue_vld  = w_issue_slot && (SKIP_INVALID || r_vpf[w_sel]);
        w_pend_left  = r_pend;
        if (w_issue_slot) w_pend_left[w_sel] = 1'b0;
        trn_vpf  = w_issue_vld;
        trn_roll = w_issue_vld ? r_roll[w_sel*ROLL_W +: ROLL_W] : '0;
        trn_pad  = w_issue_vld ? r_pad[w_sel*PAD_W +: PAD_W]    : '0;
        trn_size = w_issue_vld ? r_size[w_sel*SIZE_W +: SIZE_W] : '0;
    end

    // DRAIN lasts exactly TRN_LATENCY cycles so the final return lands before DONE,
    // which keeps done timing fixed even when trailing slots carried invalid tags.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (load) w_state_nxt = S_ISSUE;
            S_ISSUE: if (!load && w_pend_left == '0) w_state_nxt = S_DRAIN;
            S_DRAIN: if (load) w_state_nxt = S_ISSUE;
                     else if (r_drain == 2'(TRN_LATENCY - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = load ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_vpf     <= '0;
            r_roll    <= '0;
            r_pad     <= '0;
            r_size    <= '0;
            r_pend    <= '0;
            r_drain   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= (r_state == S_DRAIN && !load) ? r_drain + 2'd1 : 2'd0;
            if (load && (r_state == S_ISSUE || r_state == S_DRAIN)) r_overrun <= 1'b1;
            if (load) begin
                r_vpf  <= cl_vpf;
                r_roll <= cl_roll;
                r_pad  <= cl_pad;
                r_size <= cl_size;
                r_pend <= SKIP_INVALID ? cl_vpf : '1;
            end else begin
                r_pend <= w_pend_left;
            end
        end
    end

    gem_sched_tag_pipe #(
        .DEPTH (TRN_LATENCY)
    ) u_tag_pipe (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_flush     (load),
        .i_push_vld  (w_issue_vld),
        .i_push_slot (w_sel),
        .o_vld       (w_tag_vld),
        .o_slot      (w_tag_slot)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res_vpf  <= '0;
            r_res_me1a <= '0;
            r_res_wlo  <= '0;
            r_res_whi  <= '0;
            r_res_hlo  <= '0;
            r_res_hhi  <= '0;
        end else if (load) begin
            r_res_vpf  <= '0;
            r_res_me1a <= '0;
            r_res_wlo  <= '0;
            r_res_whi  <= '0;
            r_res_hlo  <= '0;
            r_res_hhi  <= '0;
        end else if (w_tag_vld) begin
            r_res_vpf[w_tag_slot]                  <= 1'b1;
            r_res_me1a[w_tag_slot]                 <= trn_me1a;
            r_res_wlo[w_tag_slot*WIRE_W +: WIRE_W] <= trn_wire_lo;
            r_res_whi[w_tag_slot*WIRE_W +: WIRE_W] <= trn_wire_hi;
            r_res_hlo[w_tag_slot*HS_W +: HS_W]     <= trn_hs_lo;
            r_res_hhi[w_tag_slot*HS_W +: HS_W]     <= trn_hs_hi;
        end
    end

    assign res_vpf     = r_res_vpf;
    assign res_me1a    = r_res_me1a;
    assign res_wire_lo = r_res_wlo;
    assign res_wire_hi = r_res_whi;
    assign res_hs_lo   = r_res_hlo;
    assign res_hs_hi   = r_res_hhi;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_gem_cluster_lut_scheduler.sv
// Scoreboard bench for gem_cluster_lut_scheduler with a delay-line translator model.
module tb_gem_cluster_lut_scheduler;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  cl_vpf = '0;
    logic [23:0] cl_roll = '0;
    logic [63:0] cl_pad = '0;
    logic [23:0] cl_size = '0;
    logic        trn_vpf;
    logic [2:0]  trn_roll, trn_size;
    logic [7:0]  trn_pad;
    logic [5:0]  trn_wire_lo, trn_wire_hi;
    logic [7:0]  trn_hs_lo, trn_hs_hi;
    logic        trn_me1a;
    logic [7:0]  res_vpf, res_me1a;
    logic [47:0] res_wire_lo, res_wire_hi;
    logic [63:0] res_hs_lo, res_hs_hi;
    logic        busy, done, overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_vpf = '0;

    typedef struct packed {
        logic [5:0] wlo;
        logic [5:0] whi;
        logic [7:0] hlo;
        logic [7:0] hhi;
        logic       me1a;
    } xres_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  roll;
        logic [7:0]  pad;
        logic [2:0]  size;
    } iss_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  vpf;
        logic [47:0] wlo;
        logic [47:0] whi;
        logic [63:0] hlo;
        logic [63:0] hhi;
        logic [7:0]  me1a;
        logic        ovr;
    } dn_t;

    iss_t iq[$];
    dn_t  dq[$];

    function automatic xres_t xl(input logic [2:0] roll, input logic [7:0] pad, input logic [2:0] size);
        xres_t r;
        r.wlo  = pad[5:0];
        r.whi  = pad[5:0] + {3'b000, size};
        r.hlo  = pad;
        r.hhi  = pad + {5'b00000, size};
        r.me1a = (roll == 3'd7);
        return r;
    endfunction

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Translator stand-in: returns the window for what was issued LAT clocks earlier.
    logic [2:0] m_roll [LAT];
    logic [7:0] m_pad  [LAT];
    logic [2:0] m_size [LAT];
    always @(posedge clock) begin
        m_roll[0] <= trn_roll;
        m_pad[0]  <= trn_pad;
        m_size[0] <= trn_size;
        for (int i = 1; i < LAT; i++) begin
            m_roll[i] <= m_roll[i-1];
            m_pad[i]  <= m_pad[i-1];
            m_size[i] <= m_size[i-1];
        end
    end
    xres_t m_out;
    assign m_out       = xl(m_roll[LAT-1], m_pad[LAT-1], m_size[LAT-1]);
    assign trn_wire_lo = m_out.wlo;
    assign trn_wire_hi = m_out.whi;
    assign trn_hs_lo   = m_out.hlo;
    assign trn_hs_hi   = m_out.hhi;
    assign trn_me1a    = m_out.me1a;

    gem_cluster_lut_scheduler #(
        .NCLUSTERS   (8),
        .TRN_LATENCY (LAT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (load),
        .cl_vpf      (cl_vpf),
        .cl_roll     (cl_roll),
        .cl_pad      (cl_pad),
        .cl_size     (cl_size),
        .trn_vpf     (trn_vpf),
        .trn_roll    (trn_roll),
        .trn_pad     (trn_pad),
        .trn_size    (trn_size),
        .trn_wire_lo (trn_wire_lo),
        .trn_wire_hi (trn_wire_hi),
        .trn_hs_lo   (trn_hs_lo),
        .trn_hs_hi   (trn_hs_hi),
        .trn_me1a    (trn_me1a),
        .res_vpf     (res_vpf),
        .res_wire_lo (res_wire_lo),
        .res_wire_hi (res_wire_hi),
        .res_hs_lo   (res_hs_lo),
        .res_hs_hi   (res_hs_hi),
        .res_me1a    (res_me1a),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        iss_t ei;
        dn_t  ed;
        if (trn_vpf) begin
            if (iq.size() == 0) chk("unexpected_issue", 64'(cyc), 64'(0));
            else begin
                ei = iq.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(ei.cyc));
                chk("issue_roll", 64'(trn_roll), 64'(ei.roll));
                chk("issue_pad", 64'(trn_pad), 64'(ei.pad));
                chk("issue_size", 64'(trn_size), 64'(ei.size));
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 64'(cyc), 64'(0));
            else begin
                ed = dq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(ed.cyc));
                chk("res_vpf", 64'(res_vpf), 64'(ed.vpf));
                chk("res_wire_lo", 64'(res_wire_lo), 64'(ed.wlo));
                chk("res_wire_hi", 64'(res_wire_hi), 64'(ed.whi));
                chk("res_hs_lo", res_hs_lo, ed.hlo);
                chk("res_hs_hi", res_hs_hi, ed.hhi);
                chk("res_me1a", 64'(res_me1a), 64'(ed.me1a));
                chk("overrun", 64'(overrun), 64'(ed.ovr));
            end
        end
    end

    task automatic expect_load(input logic [7:0] vpf, input logic [23:0] roll, input logic [63:0] pad,
                               input logic [23:0] size, input int t, input logic ovr);
        int    n;
        dn_t   d;
        iss_t  s;
        xres_t x;
        n = 0;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            s.roll = roll[i*3 +: 3];
            s.pad  = pad[i*8 +: 8];
            s.size = size[i*3 +: 3];
            if (vpf[i]) begin
`ifdef GEM_SCHED_SKIP_INVALID_EN
                n++;
                s.cyc = 32'(t + n);
`else
                s.cyc = 32'(t + 1 + i);
`endif
                iq.push_back(s);
                x = xl(s.roll, s.pad, s.size);
                d.vpf[i]        = 1'b1;
                d.me1a[i]       = x.me1a;
                d.wlo[i*6 +: 6] = x.wlo;
                d.whi[i*6 +: 6] = x.whi;
                d.hlo[i*8 +: 8] = x.hlo;
                d.hhi[i*8 +: 8] = x.hhi;
            end
        end
`ifndef GEM_SCHED_SKIP_INVALID_EN
        n = 8;
`endif
        d.cyc = 32'(t + ((n > 0) ? n : 1) + LAT + 1);
        d.ovr = ovr;
        dq.push_back(d);
        exp_vpf = vpf;
    endtask

    task automatic do_load(input logic [7:0] vpf, input logic [23:0] roll, input logic [63:0] pad,
                           input logic [23:0] size, input logic ovr, output int t);
        load    = 1'b1;
        cl_vpf  = vpf;
        cl_roll = roll;
        cl_pad  = pad;
        cl_size = size;
        t = cyc;
        expect_load(vpf, roll, pad, size, t, ovr);
        @(posedge clock);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || busy) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({name, "_timeout"}, 64'(n < 200), 64'(1));
        chk({name, "_hold_vpf"}, 64'(res_vpf), 64'(exp_vpf));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, 64'({trn_vpf, trn_roll, trn_pad, trn_size, busy, done, overrun, res_vpf, res_me1a}), 64'(0));
        chk({name, "_wire"}, 64'({res_wire_lo, res_wire_hi}), 64'(0));
        chk({name, "_hs_lo"}, res_hs_lo, 64'(0));
        chk({name, "_hs_hi"}, res_hs_hi, 64'(0));
    endtask

    localparam logic [23:0] RA = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [63:0] PA = {8'd191, 8'd150, 8'd77, 8'd64, 8'd33, 8'd20, 8'd5, 8'd0};
    localparam logic [23:0] SA = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    localparam logic [23:0] RB = {3'd7, 3'd0, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    localparam logic [63:0] PB = {8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30};
    localparam logic [23:0] SB = {3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    initial begin
        int t;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_load(8'b0010_0101, RA, PA, SA, 1'b0, t);
        wait_quiet("mixed");

        do_load(8'h00, RA, PA, SA, 1'b0, t);
        wait_quiet("empty");

        do_load(8'hFF, RB, PB, SB, 1'b0, t);
        wait_quiet("full");

        // Abort: second load two cycles in; first sequence keeps only its first two issues.
        do_load(8'h0F, RA, PA, SA, 1'b0, t);
        @(posedge clock);
        #1;
        while (iq.size() != 0 && iq[$].cyc > 32'(cyc)) void'(iq.pop_back());
        void'(dq.pop_back());
        do_load(8'hC0, RB, PB, SB, 1'b1, t);
        wait_quiet("abort");

        // Reset in DRAIN while the last return is still in flight.
        do_load(8'hFF, RA, PA, SA, 1'b1, t);
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        iq.delete();
        dq.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check_zero("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
